map_query_arbiter: RTL

Shared wall-lookup responder for all maze movers (Pac-Man, ghosts). Each mover raises a request carrying a candidate pixel position. The block round-robin arbitrates, converts the pixel position to a tile address, and reads the wall bitmap from an external synchronous map ROM. It then returns a one-cycle acknowledge with the wall result. It replaces per-mover combinational map lookups and sits between the mover FSMs and the single map ROM port.

---
 rtl/map_query_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/map_query_arbiter.sv
// Shared wall-lookup responder: round-robin arbitration of mover queries onto a
// single synchronous map ROM port, answering each with a one-cycle ack.
module map_query_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TILE_SHIFT = 3,
  parameter int MAP_W      = 80,
  parameter int MAP_H      = 60,
  parameter int ADDR_W     = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*10-1:0]   req_x,
  input  logic [NUM_REQ*9-1:0]    req_y,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    is_wall,
  output logic                    busy,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic                    rom_data,
  output logic [1:0]              fsm_state
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [10:0] X_LIM = 11'(MAP_W << TILE_SHIFT);
  localparam logic [9:0]  Y_LIM = 10'(MAP_H << TILE_SHIFT);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t               state, state_d;
  logic [PTR_W-1:0]     ptr, ptr_d, grant, grant_d, win;
  logic                 oob, oob_d, is_wall_d, found;
  logic [ADDR_W-1:0]    rom_addr_d;
  logic [NUM_REQ-1:0]   ack_d, eff;
  logic [PTR_W:0]       idx;
  logic [9:0]           win_x;
  logic [8:0]           win_y;

  // Handshake: req[i] is a level held until ack[i] pulses for one cycle; the
  // mover's coordinates are captured only on its grant edge, and a mover whose
  // ack is high is excluded from that cycle's arbitration.
  always_comb begin
    eff   = req & ~ack;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && eff[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_x = '0;
    win_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == win) begin
        win_x = req_x[i*10 +: 10];
        win_y = req_y[i*9 +: 9];
      end
    end
  end

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    grant_d    = grant;
    oob_d      = oob;
    rom_addr_d = rom_addr;
    is_wall_d  = is_wall;
    ack_d      = '0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_d    = win;
          ptr_d      = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
          // Out-of-range positions still drive a (wrapped) address; oob overrides the read.
          rom_addr_d = ADDR_W'(win_y >> TILE_SHIFT) * ADDR_W'(MAP_W)
                     + ADDR_W'(win_x >> TILE_SHIFT);
          oob_d      = ({1'b0, win_x} >= X_LIM) || ({1'b0, win_y} >= Y_LIM);
          state_d    = WAIT;
        end
      end
      WAIT: state_d = RESP;
      RESP: begin
        is_wall_d    = oob | rom_data;
        ack_d[grant] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      oob      <= 1'b0;
      rom_addr <= '0;
      is_wall  <= 1'b0;
      ack      <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      grant    <= grant_d;
      oob      <= oob_d;
      rom_addr <= rom_addr_d;
      is_wall  <= is_wall_d;
      ack      <= ack_d;
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule
